vga_wave_scan_controller: RTL and testbench

Sequencer that feeds `vga_wave_visualization` and drives the VGA adapter's pixel-plot port. It arms on the audio sample stream and captures one screen-width snapshot of 6-bit samples, triggered on a rising zero crossing or by timeout. It then raster-scans every pixel of the 160x120 display, presents x/y and the buffered amplitude to the visualization block, and plots the returned color with a ready/valid handshake.

---
 rtl/vga_wave_scan_controller.sv | 131 +++++++++++++
 tb/tb_vga_wave_scan_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_wave_scan_controller.sv
// vga_wave_scan_controller: captures a WIDTH-sample audio snapshot on a rising zero crossing or timeout,
// then raster-scans the display through the visualization block into the VGA plot port.
module vga_wave_scan_controller #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int DECIM        = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] sample_in,
    input  logic       sample_valid,
    input  logic       enable,
    output logic [7:0] scan_x,
    output logic [6:0] scan_y,
    input  logic [7:0] wave_requested,
    output logic [5:0] wave_amplitude,
    input  logic [2:0] pixel_color,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_color,
    output logic       vga_plot,
    input  logic       vga_ready,
    output logic       busy,
    output logic       frame_done
);
    localparam int TW = AUTO_TIMEOUT > 2 ? $clog2(AUTO_TIMEOUT) : 1;
    localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
    typedef enum logic [1:0] {ARM, CAPTURE, DRAW} state_t;
    state_t state, state_nx;
    logic [5:0] snap [WIDTH];
    logic [5:0] prev;
    logic prev_ok;
    logic [TW-1:0] tmo;
    logic [7:0] wr_idx;
    logic [DW-1:0] dec_cnt;
    logic last_loaded;
    logic trig, cap_wr, cap_done, load, accept_last, scan_eol;
    assign wave_amplitude = wave_requested < 8'(WIDTH) ? snap[wave_requested] : 6'd0;
    assign busy = state != ARM;
    always_comb begin
        trig = enable && sample_valid &&
               ((prev_ok && $signed(prev) < 0 && $signed(sample_in) >= 0) || tmo == TW'(AUTO_TIMEOUT - 1));
        cap_wr = sample_valid && dec_cnt == DW'(DECIM - 1);
        cap_done = cap_wr && wr_idx == 8'(WIDTH - 1);
        load = !last_loaded && (!vga_plot || vga_ready);
        accept_last = last_loaded && vga_plot && vga_ready;
        scan_eol = scan_x == 8'(WIDTH - 1);
        state_nx = state;
        case (state)
            ARM:     state_nx = trig ? CAPTURE : ARM;
            CAPTURE: state_nx = cap_done ? DRAW : CAPTURE;
            DRAW:    state_nx = accept_last ? ARM : DRAW;
            default: state_nx = ARM;
        endcase
    end
    // Snapshot storage has no reset; its contents only matter after a full capture.
    always_ff @(posedge clk) begin
        if (state == ARM && trig)
            snap[0] <= sample_in;
        else if (state == CAPTURE && cap_wr)
            snap[wr_idx] <= sample_in;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ARM;
            prev        <= '0;
            prev_ok     <= 1'b0;
            tmo         <= '0;
            wr_idx      <= '0;
            dec_cnt     <= '0;
            last_loaded <= 1'b0;
            scan_x      <= '0;
            scan_y      <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_color   <= '0;
            vga_plot    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= 1'b0;
            case (state)
                ARM: begin
                    if (sample_valid) begin
                        prev    <= sample_in;
                        prev_ok <= 1'b1;
                    end
                    tmo <= !enable ? '0 : sample_valid ? tmo + 1'b1 : tmo;
                    if (trig) begin
                        wr_idx  <= 8'd1;
                        dec_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        dec_cnt <= cap_wr ? '0 : dec_cnt + 1'b1;
                        wr_idx  <= cap_wr ? wr_idx + 1'b1 : wr_idx;
                    end
                    if (cap_done) begin
                        scan_x      <= '0;
                        scan_y      <= '0;
                        last_loaded <= 1'b0;
                    end
                end
                DRAW: begin
                    if (load) begin
                        vga_x       <= scan_x;
                        vga_y       <= scan_y;
                        vga_color   <= pixel_color;
                        vga_plot    <= 1'b1;
                        last_loaded <= scan_eol && scan_y == 7'(HEIGHT - 1);
                        scan_x      <= scan_eol ? '0 : scan_x + 1'b1;
                        scan_y      <= scan_eol ? scan_y + 1'b1 : scan_y;
                    end
                    // Final pixel accepted: close the frame and re-arm from a clean trigger history.
                    if (accept_last) begin
                        vga_plot    <= 1'b0;
                        frame_done  <= 1'b1;
                        tmo         <= '0;
                        prev_ok     <= 1'b0;
                        last_loaded <= 1'b0;
                        scan_x      <= '0;
                        scan_y      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_wave_scan_controller.sv
// tb_vga_wave_scan_controller: randomized bench; a snapshot/raster reference fills a scoreboard queue
// that an independent monitor drains on every accepted plot.
module tb_vga_wave_scan_controller;
    localparam int W = 160, H = 120, AT = 16;
    logic clk = 1'b0, resetn = 1'b1;
    logic [5:0] sample_in = '0;
    logic sample_valid = 1'b0, enable = 1'b0, vga_ready = 1'b0;
    logic [7:0] scan_x, vga_x, wave_requested;
    logic [6:0] scan_y, vga_y;
    logic [5:0] wave_amplitude;
    logic [2:0] pixel_color, vga_color;
    logic vga_plot, busy, frame_done;
    logic probe_en = 1'b0;
    logic [7:0] probe_idx = '0;
    int checks = 0, errors = 0, frames = 0;
    int snap [W];
    logic [17:0] exp_q [$];
    int m_prev = 0, m_tmo = 0;
    bit m_pok = 0;
    bit exp_done = 0, stalled = 0;
    logic [18:0] held = '0;

    vga_wave_scan_controller #(.WIDTH(W), .HEIGHT(H), .AUTO_TIMEOUT(AT), .DECIM(1)) dut (
        .clk(clk), .resetn(resetn), .sample_in(sample_in), .sample_valid(sample_valid), .enable(enable),
        .scan_x(scan_x), .scan_y(scan_y), .wave_requested(wave_requested), .wave_amplitude(wave_amplitude),
        .pixel_color(pixel_color), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
        .vga_ready(vga_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Stand-in for the visualization block: one green dot per column at row 29 - amplitude.
    always_comb begin
        wave_requested = probe_en ? probe_idx : scan_x;
        pixel_color = (int'(scan_y) == 29 - int'($signed(wave_amplitude))) ? 3'h2 : 3'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, int'(act), int'(exp));
        end
    endtask

    task automatic fail(input string name, input int waited);
        checks++;
        errors++;
        $display("FAIL %s: bound expired after %0d cycles, event required", name, waited);
    endtask

    task automatic drive_now(input bit v, input int s, input bit en, input bit rdy);
        sample_valid = v;
        sample_in = 6'(s);
        enable = en;
        vga_ready = rdy;
    endtask

    task automatic step(input bit v, input int s, input bit en, input bit rdy);
        @(posedge clk);
        #2;
        drive_now(v, s, en, rdy);
    endtask

    function automatic int sx(input int n);
        return ((n + 32) % 64) - 32;
    endfunction

    // Arming rules in plain integer form; returns whether this sample starts a capture.
    function automatic bit arm_model(input bit v, input int s, input bit en);
        bit t;
        t = en && v && ((m_pok && m_prev < 0 && s >= 0) || m_tmo == AT - 1);
        if (v) begin
            m_prev = s;
            m_pok = 1;
        end
        m_tmo = !en ? 0 : v ? m_tmo + 1 : m_tmo;
        return t;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_vga_x"}, vga_x, 0);
        chk({tag, "_vga_y"}, vga_y, 0);
        chk({tag, "_vga_color"}, vga_color, 0);
        chk({tag, "_vga_plot"}, vga_plot, 0);
        chk({tag, "_scan_x"}, scan_x, 0);
        chk({tag, "_scan_y"}, scan_y, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // kind 0: scripted -3,-1,2 then ramp; kind 1: constant +5; kind 2: random samples
    task automatic session(input int kind);
        int script [3] = '{-3, -1, 2};
        bit t = 0, v;
        int s = 0, n = 0, k = 1, guard = 0;
        while (!t && guard < 500) begin
            chk("busy_in_arm", busy, 0);
            v = kind == 1 || $urandom_range(0, 3) != 0;
            s = kind == 0 ? (n < 3 ? script[n] : sx(n)) : kind == 1 ? 5 : int'($urandom_range(0, 63)) - 32;
            step(v, s, 1'b1, 1'b1);
            t = arm_model(v, s, 1'b1);
            n += int'(v);
            guard++;
        end
        if (!t) begin
            fail("trigger", guard);
            return;
        end
        snap[0] = s;
        while (k < W) begin
            v = kind == 1 || $urandom_range(0, 3) != 0;
            s = kind == 0 ? sx(n) : kind == 1 ? 5 : int'($urandom_range(0, 63)) - 32;
            step(v, s, 1'($urandom_range(0, 1)), 1'b1);
            chk("busy_in_capture", busy, 1);
            if (v) begin
                snap[k] = s;
                k++;
                n++;
            end
        end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back({8'(x), 7'(y), (y == 29 - snap[x]) ? 3'h2 : 3'h0});
    endtask

    // mode 0: ready high with a 10-cycle stall at (37,4); 1: random ready; 2: reset at (80,60)
    task automatic draw(input int mode);
        int f0 = frames, guard = 0;
        bit stall_done = 0;
        while (frames == f0 && guard < 40000) begin
            @(posedge clk);
            #2;
            if (mode != 1 && !stall_done && vga_plot && vga_x == 8'd37 && vga_y == 7'd4) begin
                vga_ready = 1'b0;
                repeat (10) step(0, 0, 1'b1, 1'b0);
                chk("stall_vga_x", vga_x, 37);
                chk("stall_vga_y", vga_y, 4);
                chk("stall_vga_plot", vga_plot, 1);
                stall_done = 1;
            end
            if (mode == 2 && vga_plot && vga_x == 8'd80 && vga_y == 7'd60) begin
                resetn = 1'b0;
                #1;
                chk_zero("mid_reset");
                exp_q.delete();
                m_prev = 0;
                m_pok = 0;
                m_tmo = 0;
                repeat (3) step(0, 0, 1'b1, 1'b1);
                resetn = 1'b1;
                return;
            end
            drive_now(busy && $urandom_range(0, 1) != 0, int'($urandom_range(0, 63)) - 32,
                      1'($urandom_range(0, 1)), mode == 1 ? $urandom_range(0, 3) != 0 : 1'b1);
            guard++;
        end
        if (frames == f0) fail("frame_done_wait", guard);
        m_pok = 0;
        m_tmo = 0;
    endtask

    task automatic probe();
        int idx [7] = '{0, 1, 2, 100, 159, 160, 255};
        step(0, 0, 1'b1, 1'b1);
        probe_en = 1'b1;
        foreach (idx[i]) begin
            probe_idx = 8'(idx[i]);
            #1;
            chk($sformatf("buf[%0d]", idx[i]), $signed(wave_amplitude), idx[i] < W ? snap[idx[i]] : 0);
        end
        probe_en = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [17:0] pix;
        if (!resetn) begin
            exp_done = 0;
            stalled = 0;
        end else begin
            if (stalled) chk("stall_hold", {vga_x, vga_y, vga_color, vga_plot}, held);
            if (frame_done || exp_done) begin
                chk("frame_done", frame_done, exp_done);
                if (frame_done) begin
                    chk("busy_at_frame_done", busy, 0);
                    frames++;
                end
            end
            exp_done = 0;
            stalled = vga_plot && !vga_ready;
            held = {vga_x, vga_y, vga_color, vga_plot};
            if (vga_plot && vga_ready) begin
                if (exp_q.size() == 0) chk("plot_without_expect", vga_plot, 0);
                else begin
                    pix = exp_q.pop_front();
                    chk($sformatf("pixel(%0d,%0d)", pix[17:10], pix[9:3]), {vga_x, vga_y, vga_color}, pix);
                    exp_done = exp_q.size() == 0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached with %0d frames done", frames);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)) - 32,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_zero("reset");
        end
        step(0, 0, 1'b1, 1'b1);
        resetn = 1'b1;
        step(1, -5, 1'b1, 1'b1);
        void'(arm_model(1, -5, 1'b1));
        step(0, 0, 1'b1, 1'b1);
        chk("busy_after_first_sample", busy, 0);
        session(0);
        draw(0);
        probe();
        for (int i = 0; i < 40; i++) begin
            step(1, 5, 1'b0, 1'b1);
            void'(arm_model(1, 5, 1'b0));
            chk("busy_enable_low", busy, 0);
        end
        session(1);
        draw(1);
        session(2);
        draw(2);
        repeat (50) begin
            step(0, 0, 1'b1, 1'b1);
            chk("busy_after_mid_reset", busy, 0);
        end
        session(2);
        draw(0);
        probe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
